// File: rtl/sigma_mem_arb_if.sv
// MemSplit32 bundle between the tile masters, the arbiter and the shared slave port.
// The arbiter takes the slave modport; the tile masters and the memory take the master modport.
interface sigma_mem_arb_if #(
   parameter int unsigned N_MASTERS = 2
);
   logic [N_MASTERS-1:0]    m_req_i;
   logic [N_MASTERS-1:0]    m_ack_o;
   logic [N_MASTERS*32-1:0] m_addr_i;
   logic [N_MASTERS-1:0]    m_we_i;
   logic [N_MASTERS*32-1:0] m_wdata_i;
   logic [N_MASTERS*4-1:0]  m_be_i;
   logic [N_MASTERS-1:0]    m_resp_o;
   logic [31:0]             m_rdata_o;

   logic                    s_req_o;
   logic [31:0]             s_addr_o;
   logic                    s_we_o;
   logic [31:0]             s_wdata_o;
   logic [3:0]              s_be_o;
   logic                    s_ack_i;
   logic                    s_resp_i;
   logic [31:0]             s_rdata_i;

   modport slave (
      input  m_req_i, m_addr_i, m_we_i, m_wdata_i, m_be_i, s_ack_i, s_resp_i, s_rdata_i,
      output m_ack_o, m_resp_o, m_rdata_o, s_req_o, s_addr_o, s_we_o, s_wdata_o, s_be_o
   );

   modport master (
      output m_req_i, m_addr_i, m_we_i, m_wdata_i, m_be_i, s_ack_i, s_resp_i, s_rdata_i,
      input  m_ack_o, m_resp_o, m_rdata_o, s_req_o, s_addr_o, s_we_o, s_wdata_o, s_be_o
   );
endinterface

// File: rtl/sigma_mem_arb.sv
// Shares one MemSplit32 slave port among N_MASTERS masters; in-order read responses via ID FIFO.
// Define SIGMA_ARB_RR_EN for round-robin arbitration; otherwise the lowest eligible index wins.
module sigma_mem_arb #(
   parameter int unsigned N_MASTERS       = 2,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   sigma_mem_arb_if.slave    bus,
   output logic              err_o
);
   localparam int unsigned IdW  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e               state_q;
   logic [IdW-1:0]       lock_q;
   logic [IdW-1:0]       fifo_q [MAX_OUTSTANDING];
   logic [PtrW-1:0]      wr_q, rd_q;
   logic [CntW-1:0]      cnt_q;
   logic                 err_q;
`ifdef SIGMA_ARB_RR_EN
   logic [IdW-1:0]       rr_q;
`endif

   logic                 fifo_full, fifo_empty;
   logic [N_MASTERS-1:0] eligible;
   logic                 gnt_found, gnt_valid;
   logic [IdW-1:0]       gnt_idx, gnt;
   logic                 accept, push, pop;

   assign fifo_full  = (cnt_q == CntW'(MAX_OUTSTANDING));
   assign fifo_empty = (cnt_q == '0);
   // A full FIFO blocks new reads even if a pop lands this cycle.
   assign eligible   = bus.m_req_i & (bus.m_we_i | {N_MASTERS{~fifo_full}});

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
`ifdef SIGMA_ARB_RR_EN
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         if (!gnt_found && eligible[(32'(rr_q) + i) % N_MASTERS]) begin
            gnt_found = 1'b1;
            gnt_idx   = IdW'((32'(rr_q) + i) % N_MASTERS);
         end
      end
`else
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            gnt_found = 1'b1;
            gnt_idx   = IdW'(i);
         end
      end
`endif
   end

   // Reset gates the grant so nothing leaks to the slave while rst_ni is low.
   assign gnt_valid = rst_ni & ((state_q == StLocked) | gnt_found);
   assign gnt       = (state_q == StLocked) ? lock_q : gnt_idx;

   always_comb begin
      bus.s_req_o   = 1'b0;
      bus.s_addr_o  = '0;
      bus.s_we_o    = 1'b0;
      bus.s_wdata_o = '0;
      bus.s_be_o    = '0;
      bus.m_ack_o   = '0;
      if (gnt_valid) begin
         bus.s_req_o   = bus.m_req_i[gnt];
         bus.s_addr_o  = bus.m_addr_i[gnt*32 +: 32];
         bus.s_we_o    = bus.m_we_i[gnt];
         bus.s_wdata_o = bus.m_wdata_i[gnt*32 +: 32];
         bus.s_be_o    = bus.m_be_i[gnt*4 +: 4];
         bus.m_ack_o[gnt] = bus.s_ack_i;
      end
   end

   assign accept = bus.s_req_o & bus.s_ack_i;
   assign push   = accept & ~bus.m_we_i[gnt];
   assign pop    = bus.s_resp_i & ~fifo_empty;

   always_comb begin
      bus.m_resp_o = '0;
      if (pop) bus.m_resp_o[fifo_q[rd_q]] = 1'b1;
   end

   assign bus.m_rdata_o = bus.s_rdata_i;
   assign err_o         = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         lock_q  <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
`ifdef SIGMA_ARB_RR_EN
         rr_q    <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (gnt_valid && !bus.s_ack_i) begin
                  state_q <= StLocked;
                  lock_q  <= gnt;
               end
            end
            StLocked: begin
               if (bus.s_ack_i) state_q <= StIdle;
            end
         endcase
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         if (bus.s_resp_i && fifo_empty) err_q <= 1'b1;
`ifdef SIGMA_ARB_RR_EN
         if (accept) rr_q <= (32'(gnt) == N_MASTERS - 1) ? '0 : gnt + 1'b1;
`endif
      end
   end

   // ID storage needs no reset; validity is tracked by cnt_q.
   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_q] <= gnt;
   end
endmodule

// File: tb/tb_sigma_mem_arb.sv
// Self-checking bench for sigma_mem_arb: vector table, directed corner sequences and random traffic
// against a queue-based reference model. Honours SIGMA_ARB_RR_EN like the design.
module tb_sigma_mem_arb;
   localparam int unsigned N    = 3;
   localparam int unsigned MAXO = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic err;
   always #5 clk = ~clk;

   sigma_mem_arb_if #(.N_MASTERS(N)) bus ();

   sigma_mem_arb #(.N_MASTERS(N), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus),
      .err_o  (err)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: list of outstanding read owners, current lock owner, priority start.
   int q[$];
   int owner = -1;
   int rr    = 0;
   bit merr  = 1'b0;
   bit last_acc;
   int last_g;

   // Staged stimulus, applied at the falling edge.
   logic [N-1:0]    st_req, st_we;
   logic [N*32-1:0] st_addr, st_wdata;
   logic [N*4-1:0]  st_be;
   logic            st_ack, st_resp;
   logic [31:0]     st_rdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick();
      int start;
`ifdef SIGMA_ARB_RR_EN
      start = rr;
`else
      start = 0;
`endif
      for (int i = 0; i < int'(N); i++) begin
         int k;
         k = (start + i) % int'(N);
         if (bus.m_req_i[k] && (bus.m_we_i[k] || q.size() < int'(MAXO))) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      q.delete();
      owner = -1;
      rr    = 0;
      merr  = 1'b0;
   endtask

   task automatic model_check();
      int g;
      bit acc;
      logic [N-1:0] e_ack, e_resp;
      logic e_sreq, e_we;
      logic [31:0] e_addr, e_wdata;
      logic [3:0] e_be;
      g      = (owner >= 0) ? owner : pick();
      e_ack  = '0;
      e_resp = '0;
      e_sreq = 1'b0;
      e_we   = 1'b0;
      e_addr = '0;
      e_wdata = '0;
      e_be   = '0;
      if (g >= 0) begin
         e_sreq  = bus.m_req_i[g];
         e_we    = bus.m_we_i[g];
         e_addr  = bus.m_addr_i[g*32 +: 32];
         e_wdata = bus.m_wdata_i[g*32 +: 32];
         e_be    = bus.m_be_i[g*4 +: 4];
         if (bus.s_ack_i) e_ack[g] = 1'b1;
      end
      if (bus.s_resp_i && q.size() > 0) e_resp[q[0]] = 1'b1;
      chk("s_req",   64'(bus.s_req_o),   64'(e_sreq));
      chk("s_addr",  64'(bus.s_addr_o),  64'(e_addr));
      chk("s_we",    64'(bus.s_we_o),    64'(e_we));
      chk("s_wdata", 64'(bus.s_wdata_o), 64'(e_wdata));
      chk("s_be",    64'(bus.s_be_o),    64'(e_be));
      chk("m_ack",   64'(bus.m_ack_o),   64'(e_ack));
      chk("m_resp",  64'(bus.m_resp_o),  64'(e_resp));
      chk("m_rdata", 64'(bus.m_rdata_o), 64'(bus.s_rdata_i));
      chk("err",     64'(err),           64'(merr));
      acc = (g >= 0) && bus.m_req_i[g] && bus.s_ack_i;
      if (bus.s_resp_i) begin
         if (q.size() > 0) void'(q.pop_front());
         else merr = 1'b1;
      end
      if (acc && !bus.m_we_i[g]) q.push_back(g);
      if (owner < 0 && g >= 0 && !bus.s_ack_i) owner = g;
      else if (owner >= 0 && bus.s_ack_i) owner = -1;
      if (acc) rr = (g + 1) % int'(N);
      last_acc = acc;
      last_g   = g;
   endtask

   task automatic drive_bus();
      bus.m_req_i   = st_req;
      bus.m_we_i    = st_we;
      bus.m_addr_i  = st_addr;
      bus.m_wdata_i = st_wdata;
      bus.m_be_i    = st_be;
      bus.s_ack_i   = st_ack;
      bus.s_resp_i  = st_resp;
      bus.s_rdata_i = st_rdata;
   endtask

   task automatic cycle();
      @(negedge clk);
      drive_bus();
      #1;
      model_check();
   endtask

   task automatic set_ctl(input logic [N-1:0] req, input logic [N-1:0] we, input logic ack,
                          input logic resp);
      st_req   = req;
      st_we    = we;
      st_ack   = ack;
      st_resp  = resp;
      st_rdata = $urandom;
   endtask

   task automatic idle_inputs();
      set_ctl('0, '0, 1'b0, 1'b0);
      drive_bus();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      #1;
      chk("rst_s_req", 64'(bus.s_req_o), 64'(0));
      chk("rst_err",   64'(err),         64'(0));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] we;
      logic         ack;
      logic         resp;
      logic [N-1:0] e_ack;
      logic [N-1:0] e_resp;
      logic         e_sreq;
      logic         e_err;
   } vec_t;

   vec_t tbl[10];
   logic [N-1:0] exp_ack_a [4];
   logic [N-1:0] exp_resp_a[4];
   bit   [N-1:0] pend;

   initial begin
      tbl[0] = '{3'b001, 3'b000, 1'b1, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0};
      tbl[1] = '{3'b010, 3'b010, 1'b1, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0};
      tbl[2] = '{3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 3'b001, 1'b0, 1'b0};
      tbl[3] = '{3'b010, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0};
      tbl[4] = '{3'b011, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0};
      tbl[5] = '{3'b011, 3'b000, 1'b1, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0};
      tbl[6] = '{3'b001, 3'b000, 1'b1, 1'b1, 3'b001, 3'b010, 1'b1, 1'b0};
      tbl[7] = '{3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 3'b001, 1'b0, 1'b0};
      tbl[8] = '{3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
      tbl[9] = '{3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1};
`ifdef SIGMA_ARB_RR_EN
      exp_ack_a  = '{3'b001, 3'b010, 3'b001, 3'b010};
      exp_resp_a = '{3'b000, 3'b001, 3'b010, 3'b001};
`else
      exp_ack_a  = '{3'b001, 3'b001, 3'b001, 3'b001};
      exp_resp_a = '{3'b000, 3'b001, 3'b001, 3'b001};
`endif
      for (int k = 0; k < int'(N); k++) begin
         st_addr[k*32 +: 32]  = 32'hA000_0000 + 32'(k) * 32'h100;
         st_wdata[k*32 +: 32] = 32'h5000_0000 + 32'(k);
         st_be[k*4 +: 4]      = 4'(k + 3);
      end
      idle_inputs();
      do_reset();

      // Vector table, then error stickiness until reset.
      foreach (tbl[i]) begin
         set_ctl(tbl[i].req, tbl[i].we, tbl[i].ack, tbl[i].resp);
         cycle();
         chk($sformatf("tbl%0d_ack", i),  64'(bus.m_ack_o),  64'(tbl[i].e_ack));
         chk($sformatf("tbl%0d_resp", i), 64'(bus.m_resp_o), 64'(tbl[i].e_resp));
         chk($sformatf("tbl%0d_sreq", i), 64'(bus.s_req_o),  64'(tbl[i].e_sreq));
         chk($sformatf("tbl%0d_err", i),  64'(err),          64'(tbl[i].e_err));
      end
      for (int i = 0; i < 3; i++) begin
         set_ctl('0, '0, 1'b0, 1'b0);
         cycle();
         chk("err_sticky", 64'(err), 64'(1));
      end
      do_reset();

      // Two masters reading continuously against a single-beat slave.
      for (int i = 0; i < 4; i++) begin
         set_ctl(3'b011, 3'b000, 1'b1, (i > 0));
         cycle();
         chk($sformatf("alt%0d_ack", i),  64'(bus.m_ack_o),  64'(exp_ack_a[i]));
         chk($sformatf("alt%0d_resp", i), 64'(bus.m_resp_o), 64'(exp_resp_a[i]));
      end
      do_reset();

      // Slave stalls master 1 for three cycles while master 0 waits.
      for (int i = 0; i < 4; i++) begin
         set_ctl((i == 0) ? 3'b010 : 3'b011, 3'b000, (i == 3), 1'b0);
         cycle();
         chk($sformatf("lock%0d_addr", i), 64'(bus.s_addr_o), 64'(32'hA000_0100));
         chk($sformatf("lock%0d_ack", i),  64'(bus.m_ack_o),  64'((i == 3) ? 3'b010 : 3'b000));
      end
      set_ctl(3'b001, 3'b000, 1'b1, 1'b0);
      cycle();
      chk("lock_next_ack", 64'(bus.m_ack_o), 64'(3'b001));
      do_reset();

      // Fill the ID FIFO; only writes pass until a response frees a slot.
      for (int i = 0; i < int'(MAXO); i++) begin
         set_ctl(3'b001, 3'b000, 1'b1, 1'b0);
         cycle();
         chk("fill_ack", 64'(bus.m_ack_o), 64'(3'b001));
      end
      set_ctl(3'b011, 3'b010, 1'b1, 1'b0);
      cycle();
      chk("full_wr_ack", 64'(bus.m_ack_o), 64'(3'b010));
      set_ctl(3'b001, 3'b000, 1'b1, 1'b1);
      cycle();
      chk("full_nopt_ack",  64'(bus.m_ack_o),  64'(3'b000));
      chk("full_nopt_sreq", 64'(bus.s_req_o),  64'(0));
      chk("full_pop_resp",  64'(bus.m_resp_o), 64'(3'b001));
      set_ctl(3'b001, 3'b000, 1'b1, 1'b0);
      cycle();
      chk("full_after_ack", 64'(bus.m_ack_o), 64'(3'b001));
      do_reset();

      // Reset while LOCKED with two reads outstanding.
      for (int i = 0; i < 2; i++) begin
         set_ctl(3'b001, 3'b000, 1'b1, 1'b0);
         cycle();
      end
      set_ctl(3'b010, 3'b000, 1'b0, 1'b0);
      cycle();
      set_ctl(3'b011, 3'b000, 1'b0, 1'b0);
      cycle();
      #2;
      rst_n = 1'b0;
      bus.s_ack_i  = 1'b1;
      bus.s_resp_i = 1'b1;
      #1;
      chk("mid_rst_sreq", 64'(bus.s_req_o),  64'(0));
      chk("mid_rst_ack",  64'(bus.m_ack_o),  64'(0));
      chk("mid_rst_resp", 64'(bus.m_resp_o), 64'(0));
      chk("mid_rst_addr", 64'(bus.s_addr_o), 64'(0));
      model_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      set_ctl(3'b000, 3'b000, 1'b0, 1'b1);
      cycle();
      chk("stray_resp", 64'(bus.m_resp_o), 64'(0));
      set_ctl(3'b010, 3'b000, 1'b1, 1'b0);
      cycle();
      chk("post_rst_ack", 64'(bus.m_ack_o), 64'(3'b010));
      chk("stray_err",    64'(err),         64'(1));
      do_reset();

      // Random protocol-respecting traffic against the model.
      pend = '0;
      for (int c = 0; c < 1500; c++) begin
         for (int k = 0; k < int'(N); k++) begin
            if (!pend[k] && ($urandom % 2 == 0)) begin
               pend[k]              = 1'b1;
               st_we[k]             = ($urandom % 3 == 0);
               st_addr[k*32 +: 32]  = $urandom;
               st_wdata[k*32 +: 32] = $urandom;
               st_be[k*4 +: 4]      = 4'($urandom);
            end
         end
         st_req   = pend;
         st_ack   = ($urandom % 3 != 0);
         st_resp  = (q.size() > 0 && ($urandom % 2 == 0)) || ($urandom % 64 == 0);
         st_rdata = $urandom;
         cycle();
         if (last_acc) pend[last_g] = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sigma_mem_arb.md
# sigma_mem_arb

Arbiter that shares one MemSplit32 slave port among `N_MASTERS` MemSplit32 masters (e.g. instruction fetch, data LSU, debug) inside the sigma tile. It sequences requests one at a time, routes each request's `ack` to its issuer, and returns read responses in order using an internal grant-ID FIFO. The block sits between the tile masters and the tile's shared memory/interconnect port.

## Interface
- `N_MASTERS`, 2: number of requesters, 2..8.
- `MAX_OUTSTANDING`, 4: read responses in flight, power of two, 2..16.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `m_req_i`  in  N_MASTERS: per-master request.
- `m_ack_o`  out  N_MASTERS: per-master acceptance.
- `m_addr_i`  in  N_MASTERS*32: per-master address, master k at bits [32k+31:32k].
- `m_we_i`  in  N_MASTERS: per-master write enable.
- `m_wdata_i`  in  N_MASTERS*32: per-master write data.
- `m_be_i`  in  N_MASTERS*4: per-master byte enables.
- `m_resp_o`  out  N_MASTERS: per-master read-response strobe.
- `m_rdata_o`  out  32: read data, broadcast to all masters, qualified by `m_resp_o`.
- `s_req_o`, `s_addr_o` (32), `s_we_o`, `s_wdata_o` (32), `s_be_o` (4)  out: slave-side request.
- `s_ack_i`, `s_resp_i`  in  1: slave acceptance and read-response strobe.
- `s_rdata_i`  in  32: slave read data.
- `err_o`  out  1: sticky; set on an unexpected response.

## Operation
- Bus rules: a master holds `req` and all request fields stable until it sees `ack`. A transfer is accepted in the cycle with `req && ack`. Only reads (`we=0`) produce a later `resp`. Writes complete on `ack`.
- States are IDLE and LOCKED.
  - IDLE: the grant is chosen combinationally from eligible requesters.
  - A requester is eligible when its `req=1` and either `we=1` or the ID FIFO is not full.
  - If `s_ack_i=1` in the same cycle, the transfer completes and the block stays in IDLE. Otherwise it moves to LOCKED and latches the granted index.
  - LOCKED: the latched master is forwarded regardless of the other requesters. It returns to IDLE on `s_ack_i`.
- Slave request outputs mux the granted master's fields. `s_req_o=0` when no master is granted, and the other `s_*` outputs are then 0.
- `m_ack_o[g] = s_ack_i` for the granted index g. All other bits are 0.
- On an accepted read, the granted index is pushed into the ID FIFO (depth `MAX_OUTSTANDING`, pointers wrap modulo depth).
- On `s_resp_i`, the FIFO head is popped and `m_resp_o[head] = 1` is driven in the same cycle. `m_rdata_o = s_rdata_i` combinationally.
- Full FIFO: new reads are ineligible even if a pop happens in the same cycle (no pop-through). Writes continue to be granted.
- Push and pop in the same cycle with a non-full FIFO: both take effect and the count is unchanged.
- `s_resp_i` with an empty FIFO: `m_resp_o` stays all-zero, `err_o` is set, and the FIFO is not modified. `err_o` is cleared only by reset.
- Priority pointer `rr_q` (see Configuration) advances only on an accepted transfer, to `(g+1) mod N_MASTERS`.
- If a locked master drops `req` before `ack` (protocol violation), the block stays LOCKED. Behaviour is otherwise undefined and is not checked.

## Timing
- Request path is combinational: `m_req_i` to `s_req_o` and `s_ack_i` to `m_ack_o`, zero cycles. A single-beat slave completes a transfer in one cycle.
- Response path is combinational: `s_resp_i` to `m_resp_o`.
- Back-to-back accepted transfers from different masters are possible on consecutive cycles.
- Reset values, asynchronous on `rst_ni=0`:
  - state = IDLE, `rr_q` = 0, FIFO empty, `err_o` = 0.
  - All `m_ack_o`, `m_resp_o` and `s_req_o` are 0 while in reset.
- Reset mid-operation discards all outstanding IDs. Later stray responses set `err_o`.

## Configuration
- `SIGMA_ARB_RR_EN` defined: round-robin. The grant is the first eligible index searching upward from `rr_q` with wrap.
- `SIGMA_ARB_RR_EN` undefined: fixed priority. The lowest eligible index wins. `rr_q` is removed.
- LOCKED behaviour is identical in both modes.

## Test plan
- Masters 0 and 1 both request reads continuously, and the slave acks every cycle (RR build) -> grants alternate 0,1,0,1. Responses return in order, routed to masters 0,1,0,1.
- Same stimulus, fixed-priority build -> master 0 is granted every cycle and master 1 is starved.
- Slave delays `ack` 3 cycles on master 1's request while master 0 raises `req` -> `s_addr_o` stays at master 1's address for all 4 cycles. Master 0 is granted on the next cycle.
- 4 reads accepted with no `resp` (`MAX_OUTSTANDING=4`), then master 0 issues a read and master 1 a write -> only the write is granted. After one `s_resp_i`, the read is granted the next cycle.
- `s_resp_i` pulsed with an empty FIFO -> `m_resp_o=0`, `err_o=1` stays set, and it clears only on `rst_ni=0`.
- `rst_ni` asserted with 2 reads outstanding and LOCKED -> all outputs 0 immediately. After release, state is IDLE and the FIFO is empty.
